// File: rtl/codec_feeder.sv
// rtl/codec_feeder.sv - jitter buffer between the echo stage and the codec
// Circular sample buffer with prefill/playback control and saturating event counters.
module codec_feeder #(
  parameter int DEPTH_LOG2 = 3,
  parameter int PREFILL    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           sample_in,
  input  logic                  in_ready,
  input  logic                  codec_req,
  output logic [15:0]           sample_out,
  output logic                  out_valid,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic [7:0]            underruns,
  output logic [7:0]            overflows
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_L   = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] PREFILL_L = (DEPTH_LOG2+1)'(PREFILL);

  typedef enum logic {FILL, PLAY} state_t;

  state_t                state_q;
  logic [15:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [15:0]           sample_out_q;
  logic                  out_valid_q;
  logic [7:0]            underruns_q, overflows_q;

  logic full_w, empty_w, pop_w, underrun_w, wr_w, ovf_w;

  always_comb begin
    full_w     = (level_q == DEPTH_L);
    empty_w    = (level_q == '0);
    pop_w      = (state_q == PLAY) && codec_req && !empty_w;
    underrun_w = (state_q == PLAY) && codec_req && empty_w;
    // A simultaneous pop frees a slot, so a write to a full buffer still lands.
    wr_w       = in_ready && (!full_w || pop_w);
    ovf_w      = in_ready && full_w && !pop_w;
    level_d    = level_q + {{DEPTH_LOG2{1'b0}}, wr_w} - {{DEPTH_LOG2{1'b0}}, pop_w};
  end

  always_ff @(posedge clk) begin
    if (wr_w && !reset) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FILL;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      sample_out_q <= '0;
      out_valid_q  <= 1'b0;
      underruns_q  <= '0;
      overflows_q  <= '0;
    end else begin
      out_valid_q <= codec_req;
      level_q     <= level_d;
      if (wr_w) begin
        wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (pop_w) begin
        rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      end
      if (ovf_w && overflows_q != 8'hFF) begin
        overflows_q <= overflows_q + 8'd1;
      end
      case (state_q)
        FILL: begin
          if (codec_req) begin
            sample_out_q <= '0;
          end
          if (level_d >= PREFILL_L) begin
            state_q <= PLAY;
          end
        end
        PLAY: begin
          if (pop_w) begin
            sample_out_q <= mem_q[rd_ptr_q];
          end else if (underrun_w) begin
            // Underrun repeats the last sample and drops back to prefill.
            if (underruns_q != 8'hFF) begin
              underruns_q <= underruns_q + 8'd1;
            end
            state_q <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign sample_out = sample_out_q;
  assign out_valid  = out_valid_q;
  assign level      = level_q;
  assign full       = full_w;
  assign empty      = empty_w;
  assign underruns  = underruns_q;
  assign overflows  = overflows_q;

endmodule

// File: tb/tb_codec_feeder.sv
// tb/tb_codec_feeder.sv - randomized and directed bench for codec_feeder against a queue model
// Inputs change on the falling edge; outputs are compared 1 ns after the rising edge.
module tb_codec_feeder;

  localparam int DEPTH   = 8;
  localparam int PREFILL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_in = '0;
  logic        in_ready = 1'b0;
  logic        codec_req = 1'b0;
  logic [15:0] sample_out;
  logic        out_valid;
  logic [3:0]  level;
  logic        full, empty;
  logic [7:0]  underruns, overflows;

  codec_feeder #(.DEPTH_LOG2(3), .PREFILL(PREFILL)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .in_ready(in_ready),
    .codec_req(codec_req), .sample_out(sample_out), .out_valid(out_valid),
    .level(level), .full(full), .empty(empty),
    .underruns(underruns), .overflows(overflows)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: a queue of stored samples plus a playing flag.
  logic [15:0] m_q[$];
  logic        m_play = 1'b0;
  logic [15:0] m_so = '0;
  logic        m_ov = 1'b0;
  int          m_und = 0;
  int          m_ovf = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic inr, input logic [15:0] din, input logic req);
    logic pop;
    if (r) begin
      m_q.delete();
      m_play = 1'b0; m_so = '0; m_ov = 1'b0; m_und = 0; m_ovf = 0;
      return;
    end
    pop  = m_play && req && (m_q.size() > 0);
    m_ov = req;
    if (req) begin
      if (!m_play) m_so = '0;
      else if (pop) m_so = m_q.pop_front();
      else if (m_und < 255) m_und++;
    end
    if (inr) begin
      if (m_q.size() < DEPTH) m_q.push_back(din);
      else if (m_ovf < 255) m_ovf++;
    end
    if (m_play && req && !pop) m_play = 1'b0;
    else if (!m_play && m_q.size() >= PREFILL) m_play = 1'b1;
  endtask

  task automatic step(input logic r, input logic inr, input logic [15:0] din, input logic req);
    @(negedge clk);
    reset = r; in_ready = inr; sample_in = din; codec_req = req;
    model(r, inr, din, req);
    @(posedge clk);
    #1;
    check("level", 32'(level), 32'(m_q.size()));
    check("full", 32'(full), 32'(m_q.size() == DEPTH));
    check("empty", 32'(empty), 32'(m_q.size() == 0));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("sample_out", 32'(sample_out), 32'(m_so));
    check("underruns", 32'(underruns), 32'(m_und));
    check("overflows", 32'(overflows), 32'(m_ovf));
  endtask

  initial begin
    step(1, 0, 0, 0);
    check("rst_level", 32'(level), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);

    // Three writes then a request while still prefilling.
    for (int i = 1; i <= 3; i++) step(0, 1, 16'(i), 0);
    step(0, 0, 0, 1);
    check("fill_valid", 32'(out_valid), 1);
    check("fill_so", 32'(sample_out), 0);
    check("fill_level", 32'(level), 3);
    step(0, 0, 0, 0);
    check("fill_valid_low", 32'(out_valid), 0);

    // Fourth write reaches prefill; drain with gaps between requests.
    step(0, 1, 16'd4, 0);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 1);
      check("play_valid", 32'(out_valid), 1);
      check("play_so", 32'(sample_out), 32'(i));
      step(0, 0, 0, 0);
      check("play_gap", 32'(out_valid), 0);
      check("play_hold", 32'(sample_out), 32'(i));
    end
    check("drained_empty", 32'(empty), 1);

    step(0, 0, 0, 1);
    check("underrun_so", 32'(sample_out), 4);
    check("underrun_cnt", 32'(underruns), 1);
    step(0, 0, 0, 1);
    check("fill_after_underrun", 32'(sample_out), 0);
    check("no_second_underrun", 32'(underruns), 1);

    // Overfill: ten writes into eight slots.
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 16'(100 + i), 0);
      if (i == 7) check("full_at_8", 32'(full), 1);
    end
    check("ovf_cnt", 32'(overflows), 2);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1);
      check("ovf_read", 32'(sample_out), 32'(100 + i));
    end

    // Refill to full, then write and pop together.
    for (int i = 0; i < 8; i++) step(0, 1, 16'(300 + i), 0);
    step(0, 1, 16'd200, 1);
    check("fullrw_so", 32'(sample_out), 300);
    check("fullrw_level", 32'(level), 8);
    check("fullrw_ovf", 32'(overflows), 2);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    check("pre_rst_level", 32'(level), 5);

    // Reset wins over a same-cycle write and request.
    step(1, 1, 16'd77, 1);
    check("midrst_level", 32'(level), 0);
    check("midrst_empty", 32'(empty), 1);
    check("midrst_so", 32'(sample_out), 0);
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_ovf", 32'(overflows), 0);
    check("midrst_und", 32'(underruns), 0);
    step(0, 0, 0, 1);
    check("midrst_fill", 32'(sample_out), 0);

    // Randomized traffic with shifting producer/consumer rates.
    for (int blk = 0; blk < 12; blk++) begin
      int pw, pr;
      pw = $urandom_range(10, 90);
      pr = $urandom_range(10, 90);
      for (int c = 0; c < 300; c++) begin
        step(($urandom_range(0, 499) == 0),
             ($urandom_range(0, 99) < pw),
             16'($urandom),
             ($urandom_range(0, 99) < pr));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/codec_feeder.md
CODEC_FEEDER -- requirements
Module: codec_feeder

Interface
REQ-001 Parameter DEPTH_LOG2, default 3, log2 of buffer entries (8 entries at default).
REQ-002 Parameter PREFILL, default 4, entries required before playback starts or resumes; legal range 1..2^DEPTH_LOG2.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sample_in  input  16  signed sample from the echo stage's out port.
REQ-006 in_ready  input  1  one-cycle strobe, driven by the echo stage's out_ready; sample_in is valid while it is high.
REQ-007 codec_req  input  1  one-cycle strobe from the codec requesting the next sample.
REQ-008 sample_out  output  16  signed sample presented to the codec.
REQ-009 out_valid  output  1  one-cycle strobe; sample_out is updated in the same cycle.
REQ-010 level  output  DEPTH_LOG2+1  current number of stored entries.
REQ-011 full, empty  output  1 each  level == 2^DEPTH_LOG2 and level == 0, respectively.
REQ-012 underruns, overflows  output  8 each  saturating event counters.

Function
REQ-013 Storage SHALL be a circular buffer with write pointer, read pointer and level counter; pointers SHALL wrap modulo 2^DEPTH_LOG2.
REQ-014 in_ready with full==0 SHALL write sample_in at the write pointer and advance the write pointer.
REQ-015 in_ready with full==1 and no accepted read in the same cycle SHALL drop the sample and increment overflows (saturate at 255).
REQ-016 FSM states: FILL and PLAY; reset state is FILL.
REQ-017 FILL: codec_req SHALL produce sample_out=0 and out_valid=1 on the next cycle, SHALL NOT read the buffer, and SHALL NOT count an underrun.
REQ-018 FILL -> PLAY when the level, after this cycle's write, is >= PREFILL.
REQ-019 PLAY: codec_req with empty==0 SHALL pop the head entry; on the next cycle, sample_out equals that entry and out_valid=1.
REQ-020 PLAY: codec_req with empty==1 SHALL repeat the previous sample_out with out_valid=1 on the next cycle, increment underruns (saturate at 255), and transition to FILL.
REQ-021 Latency: codec_req to out_valid is exactly 1 cycle in all states; no fall-through of a same-cycle write.
REQ-022 Same-cycle in_ready and accepted pop SHALL perform both operations; the level is unchanged; this applies also when full.
REQ-023 Same-cycle in_ready and codec_req while empty in PLAY SHALL write the sample, count an underrun, and enter FILL (the new entry is not popped).
REQ-024 The level SHALL never exceed 2^DEPTH_LOG2 and never go below 0.
REQ-025 out_valid SHALL be low in every cycle not directly following a codec_req.
REQ-026 sample_out SHALL hold its value between out_valid strobes.

Reset
REQ-027 Reset SHALL clear pointers, the level, underruns, overflows, sample_out (0) and out_valid (0), and force state FILL; buffer contents need not be cleared.
REQ-028 Reset asserted mid-operation SHALL take effect on the next edge, overriding any same-cycle in_ready or codec_req.
REQ-029 After reset: full=0, empty=1, level=0.

Verification
REQ-030 Reset, then 3 writes (1,2,3) followed by codec_req -> out_valid next cycle, sample_out=0, state FILL, level=3, underruns=0.
REQ-031 Write 1,2,3,4 (PREFILL reached), then 4 codec_req pulses -> sample_out sequence 1,2,3,4, each out_valid exactly 1 cycle after its request, empty=1 at the end.
REQ-032 Continue with one more codec_req -> sample_out stays 4, underruns=1, state FILL.
REQ-033 Write 10 samples (100..109) with no reads -> full=1 after 8 writes, overflows=2, subsequent reads return 100..107.
REQ-034 Full buffer with simultaneous in_ready (sample 200) and codec_req -> head popped, 200 stored, level stays 8, overflows unchanged.
REQ-035 Assert reset with level=5 and a same-cycle write -> next cycle level=0, empty=1, sample_out=0, counters 0, state FILL.
